cordic_iter_ctrl: RTL and testbench



---
 rtl/cordic_pkg.sv | 34 +++
 rtl/cordic_step_unit.sv | 40 ++++
 rtl/cordic_iter_ctrl.sv | 147 ++++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC sequencer: Q2.14 scaling, pi constants,
// the atan ROM (generated by atan_table.py for BITS=16, up to 14 steps) and the FSM state type.
package cordic_pkg;

    localparam int CORDIC_BITS = 16;
    localparam int MAX_STEPS   = CORDIC_BITS - 2;
    localparam int IDX_W       = 4;

    typedef logic signed [CORDIC_BITS:0] q_t;

    localparam q_t ONE_Q     = 17'sd16384;
    localparam q_t PI_Q      = 17'sd51472;
    localparam q_t HALF_PI_Q = 17'sd25736;

    // round(atan(2^-i) * 2^14)
    localparam q_t ATAN_ROM [MAX_STEPS] = '{
        17'sd12868, 17'sd7596, 17'sd4014, 17'sd2037, 17'sd1023, 17'sd512, 17'sd256,
        17'sd128,   17'sd64,   17'sd32,   17'sd16,   17'sd8,    17'sd4,   17'sd2
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic q_t atan_lookup(input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(MAX_STEPS)) begin
            return ATAN_ROM[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/cordic_step_unit.sv
// One CORDIC rotation step: combinational next X/Y/beta for a given iteration index.
module cordic_step_unit
    import cordic_pkg::*;
#(
    parameter int W = CORDIC_BITS + 2
) (
    input  logic signed [W-1:0]     i_x,
    input  logic signed [W-1:0]     i_y,
    input  logic signed [W-1:0]     i_beta,
    input  logic        [IDX_W-1:0] i_idx,
    output logic signed [W-1:0]     o_x,
    output logic signed [W-1:0]     o_y,
    output logic signed [W-1:0]     o_beta
);

    logic signed [W-1:0] w_x_sh;
    logic signed [W-1:0] w_y_sh;
    logic signed [W-1:0] w_atan;

    assign w_x_sh = i_x >>> i_idx;
    assign w_y_sh = i_y >>> i_idx;
    assign w_atan = W'(atan_lookup(i_idx));

    // Rotate toward beta = 0: positive residual rotates counter-clockwise.
    always_comb begin
        o_x    = i_x;
        o_y    = i_y;
        o_beta = i_beta;
        if (!i_beta[W-1]) begin
            o_x    = i_x - w_y_sh;
            o_y    = i_y + w_x_sh;
            o_beta = i_beta - w_atan;
        end else begin
            o_x    = i_x + w_y_sh;
            o_y    = i_y - w_x_sh;
            o_beta = i_beta + w_atan;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sine/cosine sequencer, one operation in flight, valid/ready on both sides.
// Optional macro CORDIC_QUAD_EXT_EN adds a pi pre-rotation to extend the range to +-pi.
//
//   state   | meaning
//   IDLE    | waiting for an angle, in_ready high
//   RUN     | one rotation step per cycle, STEPS cycles
//   DONE    | result held on sinus/cosinus until out_ready
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int BITS  = CORDIC_BITS,
    parameter int STEPS = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [BITS:0] angle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [BITS:0] sinus,
    output logic signed [BITS:0] cosinus,
    output logic              busy
);

    localparam int W = BITS + 2;
    localparam logic signed [W-1:0] ONE_W = W'(ONE_Q);

    state_t r_state;
    state_t w_next_state;

    logic signed [W-1:0]     r_x;
    logic signed [W-1:0]     r_y;
    logic signed [W-1:0]     r_beta;
    logic        [IDX_W-1:0] r_step;
    logic signed [BITS:0]    r_sin;
    logic signed [BITS:0]    r_cos;

    logic signed [W-1:0] w_x_nx;
    logic signed [W-1:0] w_y_nx;
    logic signed [W-1:0] w_beta_nx;
    logic signed [W-1:0] w_angle_ext;
    logic signed [W-1:0] w_load_x;
    logic signed [W-1:0] w_load_beta;
    logic                w_accept;
    logic                w_last;

    assign w_angle_ext = {angle[BITS], angle};
    assign w_last      = (r_step == IDX_W'(STEPS - 1));

`ifdef CORDIC_QUAD_EXT_EN
    localparam logic signed [W-1:0] PI_W      = W'(PI_Q);
    localparam logic signed [W-1:0] HALF_PI_W = W'(HALF_PI_Q);

    // Angles beyond +-pi/2 are folded by pi; starting from X = -1 restores the half-turn.
    always_comb begin
        w_load_x    = ONE_W;
        w_load_beta = w_angle_ext;
        if (w_angle_ext > HALF_PI_W) begin
            w_load_x    = -ONE_W;
            w_load_beta = w_angle_ext - PI_W;
        end else if (w_angle_ext < -HALF_PI_W) begin
            w_load_x    = -ONE_W;
            w_load_beta = w_angle_ext + PI_W;
        end
    end
`else
    always_comb begin
        w_load_x    = ONE_W;
        w_load_beta = w_angle_ext;
    end
`endif

    cordic_step_unit #(.W(W)) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_beta (r_beta),
        .i_idx  (r_step),
        .o_x    (w_x_nx),
        .o_y    (w_y_nx),
        .o_beta (w_beta_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_beta <= '0;
            r_step <= '0;
            r_sin  <= '0;
            r_cos  <= '0;
        end else if (w_accept) begin
            r_x    <= w_load_x;
            r_y    <= '0;
            r_beta <= w_load_beta;
            r_step <= '0;
        end else if (r_state == ST_RUN) begin
            r_x    <= w_x_nx;
            r_y    <= w_y_nx;
            r_beta <= w_beta_nx;
            r_step <= r_step + 1'b1;
            if (w_last) begin
                r_sin <= w_y_nx[BITS:0];
                r_cos <= w_x_nx[BITS:0];
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign sinus     = r_sin;
    assign cosinus   = r_cos;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: scoreboard of expected sin/cos and acceptance times.
module tb_cordic_iter_ctrl;

    localparam int BITS  = 16;
    localparam int STEPS = 14;
    localparam int AW    = BITS + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    logic signed [BITS:0] angle;
    logic out_valid;
    logic out_ready;
    logic signed [BITS:0] sinus;
    logic signed [BITS:0] cosinus;
    logic busy;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        string name;
        int    s;
        int    c;
        int    tol;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    cordic_iter_ctrl #(.BITS(BITS), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sinus     (sinus),
        .cosinus   (cosinus),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit near(input int obs, input int expv, input int tol);
        int d;
        d = obs - expv;
        if (d < 0) d = -d;
        return d <= tol;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expectation, present the angle, and record the cycle of the accepting edge.
    task automatic send(input int a, input string name, input int s, input int c, input int tol);
        exp_t e;
        e.name = name; e.s = s; e.c = c; e.tol = tol;
        exp_q.push_back(e);
        angle    = AW'(a);
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !in_ready; k++) tick();
        tick();
        acc_q.push_back(cyc);
    endtask

    task automatic wait_out(input int limit, output bit got, output int t, output bit all_busy);
        got = 1'b0; t = 0; all_busy = 1'b1;
        for (int k = 0; k < limit; k++) begin
            if (out_valid) begin
                got = 1'b1;
                t   = cyc;
                break;
            end
            if (!busy) all_busy = 1'b0;
            tick();
        end
    endtask

    task automatic pop_exp(output exp_t e, output int ta);
        e.name = "empty"; e.s = 0; e.c = 0; e.tol = 0; ta = 0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (acc_q.size() > 0) ta = acc_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; angle = '0;
        repeat (3) tick();
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_run++; if (sinus !== '0) begin n_fail++; $display("FAIL reset_sinus: got %0d required 0", sinus); end
        n_run++; if (cosinus !== '0) begin n_fail++; $display("FAIL reset_cosinus: got %0d required 0", cosinus); end
        rst_n = 1'b1;
        tick();
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_zero();
        exp_t e; int t, ta, s, c; bit got, allb;
        send(0, "zero", 0, 26981, 4);
        in_valid = 1'b0;
        wait_out(40, got, t, allb);
        pop_exp(e, ta);
        s = sinus; c = cosinus;
        n_run++; if (!got) begin n_fail++; $display("FAIL zero_timeout: out_valid got 0 required 1"); end
        n_run++; if (t - ta !== STEPS) begin n_fail++; $display("FAIL zero_latency: got %0d required %0d", t - ta, STEPS); end
        n_run++; if (!allb) begin n_fail++; $display("FAIL zero_busy: busy dropped during RUN, required high"); end
        n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL zero_sin: got %0d required %0d+-%0d", s, e.s, e.tol); end
        n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL zero_cos: got %0d required %0d+-%0d", c, e.c, e.tol); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_release: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_hold();
        exp_t e; int t, ta, s, c; bit got, allb, stable;
        logic signed [BITS:0] s0, c0;
        send(12868, "quarter", 19079, 19079, 4);
        in_valid = 1'b0;
        wait_out(40, got, t, allb);
        pop_exp(e, ta);
        s0 = sinus; c0 = cosinus; s = sinus; c = cosinus;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!out_valid || sinus !== s0 || cosinus !== c0 || in_ready || !busy) stable = 1'b0;
        end
        n_run++; if (!got || t - ta !== STEPS) begin n_fail++; $display("FAIL hold_latency: got %0d required %0d", t - ta, STEPS); end
        n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL hold_sin: got %0d required %0d+-%0d", s, e.s, e.tol); end
        n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL hold_cos: got %0d required %0d+-%0d", c, e.c, e.tol); end
        n_run++; if (!stable) begin n_fail++; $display("FAIL hold_stable: outputs changed while out_ready low, required held"); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_ignore_in_run();
        exp_t e; int t, ta, s, c; bit got, allb;
        send(-25736, "neg_half_pi", -26981, 0, 4);
        in_valid = 1'b0;
        repeat (3) tick();
        angle = AW'(5000); in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        wait_out(40, got, t, allb);
        pop_exp(e, ta);
        s = sinus; c = cosinus;
        n_run++; if (!got || t - ta !== STEPS) begin n_fail++; $display("FAIL ignore_latency: got %0d required %0d", t - ta, STEPS); end
        n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL ignore_sin: got %0d required %0d+-%0d", s, e.s, e.tol); end
        n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL ignore_cos: got %0d required %0d+-%0d", c, e.c, e.tol); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_out(24, got, t, allb);
        n_run++; if (got !== 1'b0) begin n_fail++; $display("FAIL ignore_extra: got an extra result, required none"); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            begin
                send(0,     "b2b_0",     0,      26981, 4);
                send(8192,  "b2b_pos",   12935,  23678, 6);
                send(-8192, "b2b_neg",  -12935,  23678, 6);
                in_valid = 1'b0;
            end
            begin
                int t_prev;
                t_prev = 0;
                for (int r = 0; r < 3; r++) begin
                    exp_t e; int t, ta, s, c; bit got, allb;
                    wait_out(60, got, t, allb);
                    pop_exp(e, ta);
                    s = sinus; c = cosinus;
                    n_run++; if (!got || t - ta !== STEPS) begin n_fail++; $display("FAIL %s_latency: got %0d required %0d", e.name, t - ta, STEPS); end
                    n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL %s_sin: got %0d required %0d+-%0d", e.name, s, e.s, e.tol); end
                    n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL %s_cos: got %0d required %0d+-%0d", e.name, c, e.c, e.tol); end
                    if (r > 0) begin
                        n_run++; if (t - t_prev !== STEPS + 2) begin n_fail++; $display("FAIL %s_spacing: got %0d required %0d", e.name, t - t_prev, STEPS + 2); end
                    end
                    t_prev = t;
                    tick();
                end
            end
        join
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        exp_t e; int t, ta, s, c; bit got, allb;
        send(12868, "discard", 0, 0, 0);
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        pop_exp(e, ta);
        n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b required 0", out_valid); end
        n_run++; if (sinus !== '0 || cosinus !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %0d/%0d required 0/0", sinus, cosinus); end
        n_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: in_ready=%0b busy=%0b required 1/0", in_ready, busy); end
        send(0, "after_rst", 0, 26981, 4);
        in_valid = 1'b0;
        wait_out(40, got, t, allb);
        pop_exp(e, ta);
        s = sinus; c = cosinus;
        n_run++; if (!got || t - ta !== STEPS) begin n_fail++; $display("FAIL midrst_latency: got %0d required %0d", t - ta, STEPS); end
        n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL midrst_sin: got %0d required %0d+-%0d", s, e.s, e.tol); end
        n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL midrst_cos: got %0d required %0d+-%0d", c, e.c, e.tol); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef CORDIC_QUAD_EXT_EN
    task automatic test_quad_ext();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            exp_t e; int t, ta, s, c; bit got, allb;
            if (r == 0) send(51472, "quad_pi", 0, -26981, 4);
            else        send(-38604, "quad_m3q", -19079, -19079, 4);
            in_valid = 1'b0;
            wait_out(40, got, t, allb);
            pop_exp(e, ta);
            s = sinus; c = cosinus;
            n_run++; if (!got || t - ta !== STEPS) begin n_fail++; $display("FAIL %s_latency: got %0d required %0d", e.name, t - ta, STEPS); end
            n_run++; if (!near(s, e.s, e.tol)) begin n_fail++; $display("FAIL %s_sin: got %0d required %0d+-%0d", e.name, s, e.s, e.tol); end
            n_run++; if (!near(c, e.c, e.tol)) begin n_fail++; $display("FAIL %s_cos: got %0d required %0d+-%0d", e.name, c, e.c, e.tol); end
            tick();
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_zero();
        test_hold();
        test_ignore_in_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef CORDIC_QUAD_EXT_EN
        test_quad_ext();
`endif
        n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
